pc_unit: RTL
============

Name: pc_unit

Overview:
- Parametrised next-generation program-counter block for the single-cycle MIPS core.
- Holds the PC register and computes the next PC for sequential flow, beq/bne, j, jal and jr.
- Adds behaviour the earlier combinational next-PC logic lacks: stall hold, exception redirect with EPC capture, eret return, and a halt state.
- Drives instruction-memory addressing; all addresses are word addresses (byte address bits [ADDR_W+1:2]).

Parameters:
- ADDR_W, 30, PC word-address width; must be >= 27.
- RESET_PC, 30'h0000_0C00, word address loaded on reset; must fit ADDR_W bits.
- EXC_VECTOR, 30'h0000_1060, word address of the exception handler; must fit ADDR_W bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hold PC this cycle.
- branch  in  2  00 none, 10 beq, 11 bne, 01 reserved (treated as none).
- jump  in  2  00 none, 01 J, 10 JR, 11 JAL.
- zero  in  1  ALU equality flag for the current instruction.
- imm16  in  16  branch offset in words, signed.
- instr_index  in  26  J/JAL target field.
- rs_target  in  ADDR_W  JR target word address (rs[ADDR_W+1:2]).
- exc_req  in  1  exception request for the current instruction.
- eret  in  1  return from exception.
- halt  in  1  enter halt state.
- pc  out  ADDR_W  current PC (registered).
- link_pc  out  ADDR_W  pc+1, combinational, used as the JAL link value.
- epc  out  ADDR_W  saved exception PC (registered).
- halted  out  1  1 while in the HALT state (registered).

Behaviour:
- Reset (synchronous, wins over everything):
  - pc <= RESET_PC, epc <= 0, halted <= 0, state <= RUN.
  - Reset asserted mid-stall or in HALT behaves identically.
- States:
  - RUN: normal operation.
  - HALT: pc and epc frozen; all inputs ignored; exits only via reset.
- RUN priority, highest first:
  1. halt: state <= HALT, pc holds.
  2. exc_req: epc <= pc, pc <= EXC_VECTOR. Taken even when stall=1.
  3. eret: pc <= epc.
  4. stall: pc holds.
  5. jump != 00:
     - J: {pc[ADDR_W-1:26], instr_index}
     - JAL: same target as J.
     - JR: rs_target.
  6. Branch taken (beq & zero, or bne & !zero): pc+1+sext(imm16).
  7. Otherwise: pc+1.
- Simultaneous events:
  - exc_req and eret together: exc_req wins.
  - jump and branch together: jump wins.
  - A taken or untaken branch with stall=1 holds pc.
- Arithmetic:
  - All sums are modulo 2^ADDR_W; no overflow flag.
  - pc = all-ones plus 1 wraps to 0.
  - Backward branch offsets wrap the same way.
  - imm16 is sign-extended to ADDR_W bits.
- Latency:
  - Next-PC selection is combinational; the new pc is visible the cycle after the edge.
  - Exception redirect adds no bubble beyond that.
  - epc is updated on the same edge as the redirect.
- link_pc is combinational from pc in every state; not gated by jump.
- No delay slots.

Decomposition:
- Shared package (cpu_pkg):
  - jump encodings: NO_JUMP, J, JR, JAL.
  - branch encodings: NO_BRANCH, BEQ, BNE.
  - pc_state_t enum: RUN, HALT.
  - Default RESET_PC and EXC_VECTOR constants.
- One combinational sub-module, next_pc_calc:
  - Inputs: pc, branch, jump, zero, imm16, instr_index, rs_target.
  - Outputs: seq_pc, target_pc.
- pc_unit owns the registers, FSM and priority mux.

Test Plan:
1. Reset then 3 idle cycles → pc = 0xC00, 0xC01, 0xC02, 0xC03; epc = 0; halted = 0.
2. pc=0xC10, beq, zero=1, imm16=0xFFFE → pc = 0xC0F. Same with zero=0 → 0xC11. bne with zero=0, imm16=4 → 0xC15.
3. pc=0x2000_0005:
   - J, instr_index=0x12345 → 0x2001_2345.
   - JAL with the same instr_index → same target; link_pc = 0x2000_0006 the cycle before the edge.
   - JR, rs_target=0x400 → 0x400.
4. pc=0xC20, exc_req=1 with stall=1 and jump=J → pc = 0x1060, epc = 0xC20. Then eret=1 → pc = 0xC20. exc_req and eret together → pc = 0x1060.
5. stall=1 for 4 cycles with beq taken → pc constant. pc = 0x3FFF_FFFF sequential → 0.
6. halt=1 → halted = 1 next cycle; 5 cycles of exc_req/jump → pc and epc unchanged. reset=1 → pc = 0xC00, halted = 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings and default addresses for the single-cycle MIPS core.
// Addresses here are word addresses (byte address >> 2).
package cpu_pkg;

    typedef enum logic [1:0] {
        NO_JUMP = 2'b00,
        J       = 2'b01,
        JR      = 2'b10,
        JAL     = 2'b11
    } jump_t;

    // 2'b01 is reserved and decodes as no branch.
    typedef enum logic [1:0] {
        NO_BRANCH = 2'b00,
        BEQ       = 2'b10,
        BNE       = 2'b11
    } branch_t;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } pc_state_t;

    localparam logic [29:0] DEFAULT_RESET_PC   = 30'h0000_0C00;
    localparam logic [29:0] DEFAULT_EXC_VECTOR = 30'h0000_1060;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC candidates: sequential pc+1 and the control-flow target.
// Jumps take precedence over branches; with neither, target_pc equals seq_pc.
module next_pc_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 30
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        branch,
    input  logic [1:0]        jump,
    input  logic              zero,
    input  logic [15:0]       imm16,
    input  logic [25:0]       instr_index,
    input  logic [ADDR_W-1:0] rs_target,
    output logic [ADDR_W-1:0] seq_pc,
    output logic [ADDR_W-1:0] target_pc
);

    logic [ADDR_W-1:0] imm_ext;
    logic [ADDR_W-1:0] branch_pc;
    logic [ADDR_W-1:0] jump_pc;
    logic              branch_taken;

    assign seq_pc       = pc + ADDR_W'(1);
    assign imm_ext      = {{(ADDR_W-16){imm16[15]}}, imm16};
    assign branch_pc    = seq_pc + imm_ext;
    // ADDR_W >= 27 keeps at least one region bit above the 26-bit index.
    assign jump_pc      = {pc[ADDR_W-1:26], instr_index};
    assign branch_taken = (branch == BEQ && zero) || (branch == BNE && !zero);

    always_comb begin
        target_pc = seq_pc;
        if (jump == J || jump == JAL) begin
            target_pc = jump_pc;
        end else if (jump == JR) begin
            target_pc = rs_target;
        end else if (branch_taken) begin
            target_pc = branch_pc;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter register with stall, exception redirect/EPC capture, eret and halt.
// Priority in RUN: halt > exc_req > eret > stall > jump/branch/sequential.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = 30,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEFAULT_EXC_VECTOR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [1:0]        branch,
    input  logic [1:0]        jump,
    input  logic              zero,
    input  logic [15:0]       imm16,
    input  logic [25:0]       instr_index,
    input  logic [ADDR_W-1:0] rs_target,
    input  logic              exc_req,
    input  logic              eret,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_pc,
    output logic [ADDR_W-1:0] epc,
    output logic              halted
);

    pc_state_t         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] target_pc;

    next_pc_calc #(.ADDR_W(ADDR_W)) u_calc (
        .pc          (pc_q),
        .branch      (branch),
        .jump        (jump),
        .zero        (zero),
        .imm16       (imm16),
        .instr_index (instr_index),
        .rs_target   (rs_target),
        .seq_pc      (seq_pc),
        .target_pc   (target_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epc_d   = epc_q;
        case (state_q)
            RUN: begin
                if (halt) begin
                    state_d = HALT;
                end else if (exc_req) begin
                    // Redirect ignores stall so the faulting instruction never retires.
                    epc_d = pc_q;
                    pc_d  = EXC_VECTOR;
                end else if (eret) begin
                    pc_d = epc_q;
                end else if (!stall) begin
                    pc_d = target_pc;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
        end
    end

    assign pc      = pc_q;
    assign epc     = epc_q;
    assign halted  = (state_q == HALT);
    assign link_pc = seq_pc;

endmodule
